deco_7seg: RTL and testbench
============================

// Module: deco_7seg
// PURPOSE
//   BCD-to-seven-segment decoder with registered outputs.
//   Takes a 4-bit code on discrete inputs ai (MSB), bi, ci, di (LSB) and drives segments Ao..Go (a..g).
//   Sits between the digit/counter logic and the display pins of a single 7-segment digit.
//   Codes 0-9 always decode to decimal glyphs; codes 10-15 are governed by HEX_MODE.
// PARAMETERS
//   ACTIVE_LOW  0  1 = segment outputs inverted (common-anode display); 0 = 1 lights a segment
//   HEX_MODE    0  1 = codes 10-15 show A,b,C,d,E,F; 0 = codes 10-15 blank all segments
// PORTS
//   clk  in  1  single system clock, all state on rising edge
//   rst  in  1  synchronous reset, active-high
//   ai   in  1  code bit 3 (MSB)
//   bi   in  1  code bit 2
//   ci   in  1  code bit 1
//   di   in  1  code bit 0 (LSB)
//   Ao   out 1  segment a (top)
//   Bo   out 1  segment b (top right)
//   Co   out 1  segment c (bottom right)
//   Do   out 1  segment d (bottom)
//   Eo   out 1  segment e (bottom left)
//   Fo   out 1  segment f (top left)
//   Go   out 1  segment g (middle)
// BEHAVIOUR
//   - Interface: one clock (clk); reset is synchronous and active-high (rst).
//   - code = {ai,bi,ci,di}. Inputs are sampled at each rising clk edge.
//   - Outputs are registered; latency is 1 cycle, with no handshake.
//   - Outputs change only on clk edges and are glitch-free between edges.
//   - Reset: while rst=1 at an edge, all segments are off.
//     Off means Ao..Go = 0 when ACTIVE_LOW=0, and 1 when ACTIVE_LOW=1.
//   - rst has priority over the code input on the same edge.
//   - Decoding resumes on the first edge with rst=0.
//   - Active-high patterns, listed as abcdefg:
//       0 1111110 | 1 0110000 | 2 1101101 | 3 1111001 | 4 0110011
//       5 1011011 | 6 1011111 | 7 1110000 | 8 1111111 | 9 1111011
//       A 1110111 | b 0011111 | C 1001110 | d 0111101 | E 1001111 | F 1000111
//   - Glyph rules: 6 includes segment a; 9 includes segment d; 7 uses a,b,c only.
//   - Codes 10-15 with HEX_MODE=0 give 0000000 (blank).
//   - With ACTIVE_LOW=1, every output is the bitwise inverse of its active-high pattern, including the reset/blank state.
//   - Any X/Z on an input bit yields the blank pattern; the decoder never propagates X.
// STRUCTURE
//   - Package deco_7seg_pkg holds:
//       typedef seg7_t, a 7-bit vector packed {a,b,c,d,e,f,g};
//       constants SEG_0..SEG_9, SEG_A..SEG_F and SEG_BLANK.
//   - Sub-module deco_7seg_lut: a purely combinational 4-bit -> seg7_t lookup taking the HEX_MODE parameter.
//   - The top level does the following:
//       concatenates the input bits;
//       instantiates the LUT;
//       applies ACTIVE_LOW inversion;
//       holds the 7-bit output register with synchronous reset;
//       fans the register out to Ao..Go.
// TESTING
//   - Reset: rst=1 for 2 cycles with code 8 -> Ao..Go = 0000000; one cycle after rst drops -> 1111111.
//   - Sweep 0-9 (one code per 100 ns, several clk cycles each) -> each pattern above appears 1 cycle after the code change.
//     Spot checks: 0 -> 1111110, 1 -> 0110000, 7 -> 1110000, 9 -> 1111011.
//   - Invalid codes with HEX_MODE=0: codes 10-15 -> 0000000.
//     The same codes with HEX_MODE=1: 10 -> 1110111, 15 -> 1000111.
//   - ACTIVE_LOW=1: code 1 -> 1001111; reset -> 1111111.
//   - Back-to-back changes every cycle, 3 -> 4 -> 5 -> output sequence 1111001, 0110011, 1011011 with 1-cycle lag.
//     Assert rst mid-sequence -> blank on the next edge.

Source files
------------

// File: rtl/deco_7seg_pkg.sv
// Shared types and glyph constants for the BCD/hex to seven-segment decoder.
// Segment vectors are packed {a,b,c,d,e,f,g}, active-high.
package deco_7seg_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_0     = 7'b1111110;
    localparam seg7_t SEG_1     = 7'b0110000;
    localparam seg7_t SEG_2     = 7'b1101101;
    localparam seg7_t SEG_3     = 7'b1111001;
    localparam seg7_t SEG_4     = 7'b0110011;
    localparam seg7_t SEG_5     = 7'b1011011;
    localparam seg7_t SEG_6     = 7'b1011111;
    localparam seg7_t SEG_7     = 7'b1110000;
    localparam seg7_t SEG_8     = 7'b1111111;
    localparam seg7_t SEG_9     = 7'b1111011;
    localparam seg7_t SEG_A     = 7'b1110111;
    localparam seg7_t SEG_B     = 7'b0011111;
    localparam seg7_t SEG_C     = 7'b1001110;
    localparam seg7_t SEG_D     = 7'b0111101;
    localparam seg7_t SEG_E     = 7'b1001111;
    localparam seg7_t SEG_F     = 7'b1000111;
    localparam seg7_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/deco_7seg_lut.sv
// Combinational 4-bit code to active-high segment pattern lookup.
module deco_7seg_lut
    import deco_7seg_pkg::*;
#(
    parameter bit HEX_MODE = 1'b0
) (
    input  logic [3:0] code_i,
    output seg7_t      seg_o
);

    seg7_t hex_seg;

    // Codes 10-15 fall back to blank unless hex glyphs are enabled.
    always_comb begin
        hex_seg = SEG_BLANK;
        case (code_i)
            4'hA:    hex_seg = SEG_A;
            4'hB:    hex_seg = SEG_B;
            4'hC:    hex_seg = SEG_C;
            4'hD:    hex_seg = SEG_D;
            4'hE:    hex_seg = SEG_E;
            4'hF:    hex_seg = SEG_F;
            default: hex_seg = SEG_BLANK;
        endcase
    end

    // Unknown input bits match no item and land on the blank default.
    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'h0:    seg_o = SEG_0;
            4'h1:    seg_o = SEG_1;
            4'h2:    seg_o = SEG_2;
            4'h3:    seg_o = SEG_3;
            4'h4:    seg_o = SEG_4;
            4'h5:    seg_o = SEG_5;
            4'h6:    seg_o = SEG_6;
            4'h7:    seg_o = SEG_7;
            4'h8:    seg_o = SEG_8;
            4'h9:    seg_o = SEG_9;
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF:
                     seg_o = HEX_MODE ? hex_seg : SEG_BLANK;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/deco_7seg.sv
// Seven-segment decoder with registered, optionally inverted segment outputs.
module deco_7seg
    import deco_7seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0,
    parameter bit HEX_MODE   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic ai,
    input  logic bi,
    input  logic ci,
    input  logic di,
    output logic Ao,
    output logic Bo,
    output logic Co,
    output logic Do,
    output logic Eo,
    output logic Fo,
    output logic Go
);

    localparam seg7_t SegOff = ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    logic [3:0] code;
    seg7_t      lut_seg;
    seg7_t      seg_d;
    seg7_t      seg_q;

    assign code = {ai, bi, ci, di};

    deco_7seg_lut #(
        .HEX_MODE (HEX_MODE)
    ) u_lut (
        .code_i (code),
        .seg_o  (lut_seg)
    );

    assign seg_d = ACTIVE_LOW ? ~lut_seg : lut_seg;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= SegOff;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign {Ao, Bo, Co, Do, Eo, Fo, Go} = seg_q;

endmodule

// File: tb/tb_deco_7seg.sv
// Scoreboard bench for deco_7seg: three parameter variants driven from shared inputs.
module tb_deco_7seg;

    typedef struct packed {
        logic [6:0] dec;
        logic [6:0] hex;
        logic [6:0] al;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ai = 1'b0, bi = 1'b0, ci = 1'b0, di = 1'b0;
    logic [6:0] seg_dec, seg_hex, seg_al;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    deco_7seg #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) u_dec (
        .clk(clk), .rst(rst), .ai(ai), .bi(bi), .ci(ci), .di(di),
        .Ao(seg_dec[6]), .Bo(seg_dec[5]), .Co(seg_dec[4]), .Do(seg_dec[3]),
        .Eo(seg_dec[2]), .Fo(seg_dec[1]), .Go(seg_dec[0])
    );

    deco_7seg #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) u_hex (
        .clk(clk), .rst(rst), .ai(ai), .bi(bi), .ci(ci), .di(di),
        .Ao(seg_hex[6]), .Bo(seg_hex[5]), .Co(seg_hex[4]), .Do(seg_hex[3]),
        .Eo(seg_hex[2]), .Fo(seg_hex[1]), .Go(seg_hex[0])
    );

    deco_7seg #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) u_al (
        .clk(clk), .rst(rst), .ai(ai), .bi(bi), .ci(ci), .di(di),
        .Ao(seg_al[6]), .Bo(seg_al[5]), .Co(seg_al[4]), .Do(seg_al[3]),
        .Eo(seg_al[2]), .Fo(seg_al[1]), .Go(seg_al[0])
    );

    function automatic logic [6:0] glyph(input logic [3:0] c, input bit hex_mode);
        case (c)
            4'd0:  glyph = 7'b1111110;
            4'd1:  glyph = 7'b0110000;
            4'd2:  glyph = 7'b1101101;
            4'd3:  glyph = 7'b1111001;
            4'd4:  glyph = 7'b0110011;
            4'd5:  glyph = 7'b1011011;
            4'd6:  glyph = 7'b1011111;
            4'd7:  glyph = 7'b1110000;
            4'd8:  glyph = 7'b1111111;
            4'd9:  glyph = 7'b1111011;
            4'd10: glyph = hex_mode ? 7'b1110111 : 7'b0000000;
            4'd11: glyph = hex_mode ? 7'b0011111 : 7'b0000000;
            4'd12: glyph = hex_mode ? 7'b1001110 : 7'b0000000;
            4'd13: glyph = hex_mode ? 7'b0111101 : 7'b0000000;
            4'd14: glyph = hex_mode ? 7'b1001111 : 7'b0000000;
            default: glyph = hex_mode ? 7'b1000111 : 7'b0000000;
        endcase
    endfunction

    // Drive one cycle of stimulus and queue what each variant must show after the edge.
    task automatic drive(input logic r, input logic [3:0] c);
        exp_t e;
        rst = r;
        {ai, bi, ci, di} = c;
        e.dec = r ? 7'b0000000 : glyph(c, 1'b0);
        e.hex = r ? 7'b0000000 : glyph(c, 1'b1);
        e.al  = r ? 7'b1111111 : ~glyph(c, 1'b0);
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive((i < 2) ? 1'b1 : 1'b0, 4'd8);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({seg_dec, seg_hex, seg_al} !== {e.dec, e.hex, e.al}) begin
                errors++;
                $display("FAIL reset cyc=%0d got %b/%b/%b want %b/%b/%b",
                         i, seg_dec, seg_hex, seg_al, e.dec, e.hex, e.al);
            end
        end
        checks++;
        if (seg_dec !== 7'b1111111) begin
            errors++;
            $display("FAIL reset_release got %b want 1111111", seg_dec);
        end
    endtask

    task automatic test_sweep();
        exp_t e;
        logic [6:0] spot;
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < 10; k++) begin
                drive(1'b0, 4'(c));
                @(posedge clk); #1;
                e = sb.pop_front();
                checks++;
                if ({seg_dec, seg_hex, seg_al} !== {e.dec, e.hex, e.al}) begin
                    errors++;
                    $display("FAIL sweep code=%0d cyc=%0d got %b/%b/%b want %b/%b/%b",
                             c, k, seg_dec, seg_hex, seg_al, e.dec, e.hex, e.al);
                end
            end
            if (c == 0 || c == 1 || c == 7 || c == 9) begin
                spot = (c == 0) ? 7'b1111110 : (c == 1) ? 7'b0110000 :
                       (c == 7) ? 7'b1110000 : 7'b1111011;
                checks++;
                if (seg_dec !== spot) begin
                    errors++;
                    $display("FAIL spot code=%0d got %b want %b", c, seg_dec, spot);
                end
            end
        end
    endtask

    task automatic test_invalid();
        exp_t e;
        for (int c = 10; c < 16; c++) begin
            drive(1'b0, 4'(c));
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({seg_dec, seg_hex, seg_al} !== {e.dec, e.hex, e.al}) begin
                errors++;
                $display("FAIL invalid code=%0d got %b/%b/%b want %b/%b/%b",
                         c, seg_dec, seg_hex, seg_al, e.dec, e.hex, e.al);
            end
            if (c == 10 || c == 15) begin
                checks++;
                if (seg_hex !== ((c == 10) ? 7'b1110111 : 7'b1000111)) begin
                    errors++;
                    $display("FAIL hex_spot code=%0d got %b", c, seg_hex);
                end
            end
        end
    endtask

    task automatic test_active_low();
        exp_t e;
        drive(1'b0, 4'd1);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (seg_al !== e.al || seg_al !== 7'b1001111) begin
            errors++;
            $display("FAIL active_low_code1 got %b want 1001111", seg_al);
        end
        drive(1'b1, 4'd1);
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (seg_al !== e.al || seg_al !== 7'b1111111) begin
            errors++;
            $display("FAIL active_low_reset got %b want 1111111", seg_al);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [3:0] codes [6] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd2};
        logic       rsts  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(rsts[i], codes[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({seg_dec, seg_hex, seg_al} !== {e.dec, e.hex, e.al}) begin
                errors++;
                $display("FAIL b2b step=%0d got %b/%b/%b want %b/%b/%b",
                         i, seg_dec, seg_hex, seg_al, e.dec, e.hex, e.al);
            end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_sweep();
        test_invalid();
        test_active_low();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
